// File: rtl/ones_mask_gen_pkg.sv
// Shared widths and mask helpers for the ones-count to contiguous-mask generator.
package ones_mask_pkg;

  localparam int unsigned WL_DEFAULT = 32;

  function automatic int unsigned count_w(input int unsigned wl);
    return $clog2(wl + 1);
  endfunction

  function automatic int unsigned offset_w(input int unsigned wl);
    return $clog2(wl);
  endfunction

  // Width-specific helpers; callers pick the width with mask_fn#(WL)::fn(...)
  class mask_fn #(parameter int unsigned WL = WL_DEFAULT);
    typedef logic [WL-1:0] mask_t;

    static function mask_t therm(input int unsigned cnt);
      mask_t r;
      r = '0;
      for (int unsigned i = 0; i < WL; i++) begin
        r[i] = (i < cnt);
      end
      return r;
    endfunction

    // off is always < WL here, so the right shift never exceeds the width
    static function mask_t rotl(input mask_t m, input int unsigned off);
      return (m << off) | (m >> (WL - off));
    endfunction
  endclass

endpackage

// File: rtl/ones_mask_gen_if.sv
// Request/result valid-ready bundle for ones_mask_gen.
interface ones_mask_gen_if #(parameter int unsigned WL = 32);
  import ones_mask_pkg::*;

  localparam int unsigned CW = count_w(WL);
  localparam int unsigned OW = offset_w(WL);

  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_count;
  logic [OW-1:0] in_offset;
  logic          out_valid;
  logic          out_ready;
  logic [WL-1:0] out_mask;
  logic [CW-1:0] out_count;
  logic          out_clamped;

  modport master (
    output in_valid, in_count, in_offset, out_ready,
    input  in_ready, out_valid, out_mask, out_count, out_clamped
  );

  modport slave (
    input  in_valid, in_count, in_offset, out_ready,
    output in_ready, out_valid, out_mask, out_count, out_clamped
  );
endinterface

// File: rtl/ones_mask_gen_thermo_encode.sv
// Combinational count-to-thermometer encoder: bit i set when i < cnt.
module thermo_encode
  import ones_mask_pkg::*;
#(
  parameter int unsigned WL = 32
) (
  input  logic [count_w(WL)-1:0] cnt,
  output logic [WL-1:0]          therm
);

  always_comb begin
    therm = mask_fn#(WL)::therm(32'(cnt));
  end

endmodule

// File: rtl/ones_mask_gen.sv
// Two-stage valid/ready pipeline: clamp + thermometer encode, then rotate by offset.
module ones_mask_gen
  import ones_mask_pkg::*;
#(
  parameter int unsigned WL = 32
) (
  input  logic          clk,
  input  logic          rst,
  ones_mask_gen_if.slave bus
);

  localparam int unsigned CW = count_w(WL);
  localparam int unsigned OW = offset_w(WL);

  logic          s1_valid;
  logic [WL-1:0] s1_therm;
  logic [CW-1:0] s1_cnt;
  logic [OW-1:0] s1_off;
  logic          s1_clamped;

  logic          s2_valid;
  logic [WL-1:0] s2_mask;
  logic [CW-1:0] s2_cnt;
  logic          s2_clamped;

  logic          s1_adv;
  logic          s2_adv;
  logic [CW-1:0] cnt_c;
  logic [OW-1:0] off_c;
  logic          clamp_c;
  logic [WL-1:0] therm_c;
  logic [WL-1:0] rot_c;

  // in_ready depends combinationally on out_ready so both stages can move together
  always_comb begin
    s2_adv = !s2_valid || bus.out_ready;
    s1_adv = !s1_valid || s2_adv;
  end

  // Offset out of range only arises when WL is not a power of two
  always_comb begin
    cnt_c   = bus.in_count;
    off_c   = bus.in_offset;
    clamp_c = 1'b0;
    if (32'(bus.in_count) > WL) begin
      cnt_c   = CW'(WL);
      clamp_c = 1'b1;
    end
    if (32'(bus.in_offset) >= WL) begin
      off_c   = '0;
      clamp_c = 1'b1;
    end
  end

  thermo_encode #(.WL(WL)) u_thermo (
    .cnt   (cnt_c),
    .therm (therm_c)
  );

  always_comb begin
    rot_c = mask_fn#(WL)::rotl(s1_therm, 32'(s1_off));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_therm   <= '0;
      s1_cnt     <= '0;
      s1_off     <= '0;
      s1_clamped <= 1'b0;
      s2_valid   <= 1'b0;
      s2_mask    <= '0;
      s2_cnt     <= '0;
      s2_clamped <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_therm   <= therm_c;
          s1_cnt     <= cnt_c;
          s1_off     <= off_c;
          s1_clamped <= clamp_c;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_mask    <= rot_c;
          s2_cnt     <= s1_cnt;
          s2_clamped <= s1_clamped;
        end
      end
    end
  end

  assign bus.in_ready    = s1_adv;
  assign bus.out_valid   = s2_valid;
  assign bus.out_mask    = s2_mask;
  assign bus.out_count   = s2_cnt;
  assign bus.out_clamped = s2_clamped;

endmodule

// File: tb/tb_ones_mask_gen.sv
// Directed and randomized checks of ones_mask_gen at WL=8, WL=6 and WL=32.
module tb_ones_mask_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ones_mask_gen_if #(.WL(8))  if8 ();
  ones_mask_gen_if #(.WL(6))  if6 ();
  ones_mask_gen_if #(.WL(32)) if32 ();

  ones_mask_gen #(.WL(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  ones_mask_gen #(.WL(6))  u_dut6  (.clk(clk), .rst(rst), .bus(if6.slave));
  ones_mask_gen #(.WL(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic beat8(input logic [3:0] c, input logic [2:0] o, input logic [7:0] em,
                       input logic [3:0] ec, input logic ecl, input string tag);
    @(negedge clk);
    if8.in_valid  = 1'b1;
    if8.in_count  = c;
    if8.in_offset = o;
    check({tag, "_rdy"}, 64'(if8.in_ready), 64'd1);
    @(negedge clk);
    if8.in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(if8.out_valid), 64'd0);
    @(negedge clk);
    check({tag, "_lat2"}, 64'(if8.out_valid), 64'd1);
    check({tag, "_mask"}, 64'(if8.out_mask), 64'(em));
    check({tag, "_cnt"}, 64'(if8.out_count), 64'(ec));
    check({tag, "_clamp"}, 64'(if8.out_clamped), 64'(ecl));
  endtask

  task automatic beat6(input logic [2:0] c, input logic [2:0] o, input logic [5:0] em,
                       input logic [2:0] ec, input logic ecl, input string tag);
    @(negedge clk);
    if6.in_valid  = 1'b1;
    if6.in_count  = c;
    if6.in_offset = o;
    @(negedge clk);
    if6.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_v"}, 64'(if6.out_valid), 64'd1);
    check({tag, "_mask"}, 64'(if6.out_mask), 64'(em));
    check({tag, "_cnt"}, 64'(if6.out_count), 64'(ec));
    check({tag, "_clamp"}, 64'(if6.out_clamped), 64'(ecl));
  endtask

  function automatic logic [31:0] ref32(input int unsigned c, input int unsigned o);
    logic [31:0] m;
    int unsigned cc;
    m  = '0;
    cc = (c > 32) ? 32 : c;
    for (int unsigned j = 0; j < cc; j++) m[(o + j) % 32] = 1'b1;
    return m;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  got8[$];
    logic [31:0] expm[$];
    int unsigned expc[$];
    logic        expcl[$];
    int          sent, rcvd, cyc;
    bit          acc_prev;
    int unsigned rc, ro;
    localparam int N = 2500;

    if8.in_valid = 1'b0;  if8.in_count = '0;  if8.in_offset = '0;  if8.out_ready = 1'b1;
    if6.in_valid = 1'b0;  if6.in_count = '0;  if6.in_offset = '0;  if6.out_ready = 1'b1;
    if32.in_valid = 1'b0; if32.in_count = '0; if32.in_offset = '0; if32.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_valid", 64'(if8.out_valid), 64'd0);
    check("rst_mask", 64'(if8.out_mask), 64'd0);
    check("rst_cnt", 64'(if8.out_count), 64'd0);
    check("rst_clamp", 64'(if8.out_clamped), 64'd0);
    rst = 1'b0;

    // WL=8 directed
    beat8(4'd3, 3'd0, 8'h07, 4'd3, 1'b0, "w8_3_0");
    beat8(4'd3, 3'd6, 8'hC1, 4'd3, 1'b0, "w8_3_6");
    beat8(4'd0, 3'd5, 8'h00, 4'd0, 1'b0, "w8_0_5");
    beat8(4'd8, 3'd3, 8'hFF, 4'd8, 1'b0, "w8_8_3");
    beat8(4'd5, 3'd6, 8'hC7, 4'd5, 1'b0, "w8_5_6");
    beat8(4'd9, 3'd1, 8'hFF, 4'd8, 1'b1, "w8_9_1");

    // WL=6 clamping
    beat6(3'd7, 3'd2, 6'h3F, 3'd6, 1'b1, "w6_7_2");
    beat6(3'd2, 3'd7, 6'h03, 3'd2, 1'b1, "w6_2_7");
    beat6(3'd3, 3'd4, 6'h31, 3'd3, 1'b0, "w6_3_4");
    beat6(3'd6, 3'd5, 6'h3F, 3'd6, 1'b0, "w6_6_5");

    // WL=8 backpressure: three beats against a stalled sink
    @(negedge clk);
    if8.out_ready = 1'b0;
    if8.in_valid  = 1'b1; if8.in_count = 4'd1; if8.in_offset = 3'd0;
    check("bp_rdy_a", 64'(if8.in_ready), 64'd1);
    @(negedge clk);
    if8.in_count = 4'd2; if8.in_offset = 3'd2;
    check("bp_rdy_b", 64'(if8.in_ready), 64'd1);
    @(negedge clk);
    if8.in_count = 4'd4; if8.in_offset = 3'd4;
    check("bp_full", 64'(if8.in_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_stall_v", 64'(if8.out_valid), 64'd1);
      check("bp_stall_m", 64'(if8.out_mask), 64'h01);
      check("bp_stall_c", 64'(if8.out_count), 64'd1);
      check("bp_stall_r", 64'(if8.in_ready), 64'd0);
    end
    if8.out_ready = 1'b1;
    acc_prev = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (acc_prev) if8.in_valid = 1'b0;
      #1;
      acc_prev = if8.in_valid && if8.in_ready;
      if (if8.out_valid) got8.push_back(if8.out_mask);
      @(negedge clk);
    end
    check("bp_n", 64'(got8.size()), 64'd3);
    if (got8.size() == 3) begin
      check("bp_o0", 64'(got8[0]), 64'h01);
      check("bp_o1", 64'(got8[1]), 64'h0C);
      check("bp_o2", 64'(got8[2]), 64'hF0);
    end

    // Reset with two beats in flight
    if8.out_ready = 1'b0;
    if8.in_valid = 1'b1; if8.in_count = 4'd3; if8.in_offset = 3'd0;
    @(negedge clk);
    if8.in_count = 4'd2; if8.in_offset = 3'd1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    check("rf_pre_v", 64'(if8.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rf_v", 64'(if8.out_valid), 64'd0);
    check("rf_mask", 64'(if8.out_mask), 64'd0);
    check("rf_rdy", 64'(if8.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    if8.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rf_stale", 64'(if8.out_valid), 64'd0);
    end
    beat8(4'd4, 3'd7, 8'h87, 4'd4, 1'b0, "rf_next");

    // WL=32 random traffic with random sink stalls
    sent = 0; rcvd = 0; cyc = 0; acc_prev = 1'b0;
    while (rcvd < N && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (acc_prev) if32.in_valid = 1'b0;
      if32.out_ready = ($urandom_range(0, 3) != 0);
      if (!if32.in_valid && sent < N && $urandom_range(0, 4) != 0) begin
        rc = ($urandom_range(0, 9) == 0) ? $urandom_range(33, 63) : $urandom_range(0, 32);
        ro = $urandom_range(0, 31);
        if32.in_valid  = 1'b1;
        if32.in_count  = 6'(rc);
        if32.in_offset = 5'(ro);
      end
      #1;
      if (if32.out_valid && if32.out_ready) begin
        if (expm.size() == 0) begin
          check("rnd_extra", 64'd1, 64'd0);
        end else begin
          check("rnd_mask", 64'(if32.out_mask), 64'(expm[0]));
          check("rnd_cnt", 64'(if32.out_count), 64'(expc[0]));
          check("rnd_clamp", 64'(if32.out_clamped), 64'(expcl[0]));
          check("rnd_pop", 64'($countones(if32.out_mask)), 64'(expc[0]));
          void'(expm.pop_front());
          void'(expc.pop_front());
          void'(expcl.pop_front());
        end
        rcvd++;
      end
      acc_prev = if32.in_valid && if32.in_ready;
      if (acc_prev) begin
        expm.push_back(ref32(32'(if32.in_count), 32'(if32.in_offset)));
        expc.push_back((32'(if32.in_count) > 32) ? 32 : 32'(if32.in_count));
        expcl.push_back(32'(if32.in_count) > 32);
        sent++;
      end
    end
    check("rnd_rcvd", 64'(rcvd), 64'(N));
    check("rnd_left", 64'(expm.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
